// File: rtl/tetris_pkg.sv
// Shared board geometry, garbage-row constants and the inserter state encoding.
package tetris_pkg;

   localparam int unsigned BOARD_ROWS  = 20;
   localparam int unsigned BOARD_COLS  = 10;
   localparam int unsigned MAX_GARBAGE = 4;
   localparam int unsigned LFSR_W      = 8;

   localparam logic [BOARD_COLS-1:0] FULL_ROW = 10'h3FF;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } ins_state_t;

endpackage

// File: rtl/garbage_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that picks the hole column of garbage rows.
module garbage_lfsr
   import tetris_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       step,
   output logic [7:0] value,
   output logic [3:0] hole
);

   logic feedback;

   assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         value <= SEED;
      end else if (step) begin
         value <= {value[6:0], feedback};
      end
   end

   assign hole = 4'(value % LFSR_W'(BOARD_COLS));

endmodule

// File: rtl/row_inserter.sv
// Pushes up to four garbage rows in at the bottom of the board, one row written per cycle.
module row_inserter #(
   parameter int unsigned BOARD_ROWS = tetris_pkg::BOARD_ROWS,
   parameter int unsigned BOARD_COLS = tetris_pkg::BOARD_COLS,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic                             start,
   input  logic [BOARD_ROWS*BOARD_COLS-1:0] game_board,
   input  logic [2:0]                       row_count,
   output logic [BOARD_ROWS*BOARD_COLS-1:0] new_game_board,
   output logic                             done,
   output logic                             busy,
   output logic                             top_out
);

   import tetris_pkg::ins_state_t;
   import tetris_pkg::IDLE;
   import tetris_pkg::SHIFT;
   import tetris_pkg::DONE;
   import tetris_pkg::FULL_ROW;
   import tetris_pkg::MAX_GARBAGE;

   localparam int unsigned CW = $clog2(BOARD_ROWS);
   localparam logic [CW-1:0] LAST_ROW = CW'(BOARD_ROWS - 1);

   typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

   ins_state_t            state, state_next;
   logic [CW-1:0]         cursor, cursor_next;
   logic [CW-1:0]         src_idx;
   logic [2:0]            n_q, n_next, n_sat;
   logic [BOARD_COLS-1:0] garbage_q, garbage_next;
   board_t                board_in;
   board_t                src_q, src_next;
   board_t                out_q, out_next;
   logic                  lost_q, lost_next, lost_c;
   logic                  done_next, busy_next, top_out_next;
   logic                  lfsr_step;
   logic [3:0]            lfsr_hole;
   logic [7:0]            unused_lfsr_value;

   garbage_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .Clk   (Clk),
      .Reset (Reset),
      .step  (lfsr_step),
      .value (unused_lfsr_value),
      .hole  (lfsr_hole)
   );

   assign board_in       = game_board;
   assign new_game_board = out_q;
   assign n_sat          = (row_count > 3'(MAX_GARBAGE)) ? 3'(MAX_GARBAGE) : row_count;
   assign src_idx        = cursor - CW'(n_q);

   // Rows that will be shifted past the top for the requested count.
   always_comb begin
      lost_c = 1'b0;
      for (int unsigned r = 0; r < BOARD_ROWS; r++) begin
         if ((r + 32'(n_sat) >= BOARD_ROWS) && (board_in[r] != '0)) begin
            lost_c = 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state;
      cursor_next  = cursor;
      n_next       = n_q;
      garbage_next = garbage_q;
      src_next     = src_q;
      out_next     = out_q;
      lost_next    = lost_q;
      done_next    = 1'b0;
      busy_next    = busy;
      top_out_next = top_out;
      lfsr_step    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next   = SHIFT;
               cursor_next  = '0;
               n_next       = n_sat;
               garbage_next = BOARD_COLS'(FULL_ROW) & ~(BOARD_COLS'(1) << lfsr_hole);
               src_next     = board_in;
               lost_next    = lost_c;
               busy_next    = 1'b1;
               lfsr_step    = 1'b1;
            end
         end
         SHIFT: begin
            if (cursor < CW'(n_q)) begin
               out_next[cursor] = garbage_q;
            end else begin
               out_next[cursor] = src_q[src_idx];
            end
            if (cursor == LAST_ROW) begin
               state_next   = DONE;
               done_next    = 1'b1;
               top_out_next = lost_q;
            end else begin
               cursor_next = cursor + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         cursor    <= '0;
         n_q       <= '0;
         garbage_q <= '0;
         src_q     <= '0;
         out_q     <= '0;
         lost_q    <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         top_out   <= 1'b0;
      end else begin
         state     <= state_next;
         cursor    <= cursor_next;
         n_q       <= n_next;
         garbage_q <= garbage_next;
         src_q     <= src_next;
         out_q     <= out_next;
         lost_q    <= lost_next;
         done      <= done_next;
         busy      <= busy_next;
         top_out   <= top_out_next;
      end
   end

endmodule

// File: tb/tb_row_inserter.sv
// Scoreboard bench for row_inserter: driver queues expected boards, monitor checks each done pulse.
module tb_row_inserter;

   localparam int unsigned ROWS = 20;
   localparam int unsigned COLS = 10;
   localparam int unsigned BW   = ROWS * COLS;

   typedef struct {
      logic [BW-1:0] board;
      logic          top;
   } exp_t;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          start;
   logic [BW-1:0] game_board;
   logic [2:0]    row_count;
   logic [BW-1:0] new_game_board;
   logic          done;
   logic          busy;
   logic          top_out;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   row_inserter #(
      .BOARD_ROWS (ROWS),
      .BOARD_COLS (COLS),
      .LFSR_SEED  (8'hA5)
   ) dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .start          (start),
      .game_board     (game_board),
      .row_count      (row_count),
      .new_game_board (new_game_board),
      .done           (done),
      .busy           (busy),
      .top_out        (top_out)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Expected board after pushing n garbage rows with the given hole column.
   function automatic logic [BW-1:0] ins(input logic [BW-1:0] b, input int n, input int hole);
      logic [BW-1:0]   r;
      logic [COLS-1:0] g;
      g       = 10'h3FF;
      g[hole] = 1'b0;
      r       = '0;
      for (int i = 0; i < int'(ROWS); i++) begin
         if (i < n) r[i*COLS +: COLS] = g;
         else       r[i*COLS +: COLS] = b[(i-n)*COLS +: COLS];
      end
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", BW'(done), '0);
         end else begin
            e = exp_q.pop_front();
            check("board", new_game_board, e.board);
            check("top_out", BW'(top_out), BW'(e.top));
         end
      end
   end

   task automatic run_op(input string name, input logic [BW-1:0] b, input logic [2:0] rc,
                         input logic [BW-1:0] eb, input logic et, input logic spam);
      exp_t e;
      int   k;
      @(negedge Clk);
      game_board = b;
      row_count  = rc;
      start      = 1'b1;
      e.board    = eb;
      e.top      = et;
      exp_q.push_back(e);
      @(negedge Clk);
      start      = 1'b0;
      game_board = ~b;
      check({name, "_busy_first"}, BW'(busy), BW'(1));
      k = 1;
      while (done !== 1'b1 && k < 40) begin
         start = spam && (k == 5);
         @(negedge Clk);
         k++;
      end
      check({name, "_latency"}, BW'(k), BW'(21));
      check({name, "_busy_at_done"}, BW'(busy), BW'(1));
      start = spam;
      @(negedge Clk);
      start = 1'b0;
      check({name, "_busy_after"}, BW'(busy), '0);
      check({name, "_done_after"}, BW'(done), '0);
   endtask

   logic [BW-1:0] b, eb;

   initial begin
      Reset      = 1'b1;
      start      = 1'b0;
      row_count  = '0;
      game_board = '0;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      check("rst_board", new_game_board, '0);
      check("rst_done", BW'(done), '0);
      check("rst_busy", BW'(busy), '0);
      check("rst_top", BW'(top_out), '0);

      // Empty board, one row, hole 5 from seed A5.
      eb = '0;
      eb[9:0] = 10'h3DF;
      run_op("t1", '0, 3'd1, eb, 1'b0, 1'b0);

      // Count 7 saturates to 4, hole 4 from 4A; extra starts while busy are ignored.
      b = '0;
      for (int r = 0; r < int'(ROWS); r++) b[r*COLS +: COLS] = 10'(r + 1);
      run_op("t2", b, 3'd7, ins(b, 4, 4), 1'b1, 1'b1);
      eb = new_game_board;
      check("t2_row0", BW'(eb[9:0]), BW'(10'h3EF));
      check("t2_row3", BW'(eb[39:30]), BW'(10'h3EF));
      check("t2_row4", BW'(eb[49:40]), BW'(10'd1));

      // Row 19 occupied, two rows pushed: top out, hole 9 from 95.
      b = '0;
      for (int r = 0; r < 18; r++) b[r*COLS +: COLS] = 10'(r + 100);
      b[19*COLS +: COLS] = 10'h001;
      run_op("t3", b, 3'd2, ins(b, 2, 9), 1'b1, 1'b0);
      check("t3_hold_top", BW'(top_out), BW'(1));

      // Zero rows: board passes through unchanged even with row 19 set.
      b = '0;
      for (int r = 0; r < int'(ROWS); r++) b[r*COLS +: COLS] = 10'((r * 53 + 7) & 10'h3FF);
      run_op("t4", b, 3'd0, b, 1'b0, 1'b0);

      // Three rows with rows 17..19 empty: no top out, hole 4 from 54.
      b = '0;
      for (int r = 0; r <= 16; r++) b[r*COLS +: COLS] = 10'(r + 1);
      run_op("t5", b, 3'd3, ins(b, 3, 4), 1'b0, 1'b0);

      // Reset at cursor 10 abandons the operation.
      @(negedge Clk);
      game_board = '1;
      row_count  = 3'd4;
      start      = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      repeat (10) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("abort_board", new_game_board, '0);
      check("abort_busy", BW'(busy), '0);
      check("abort_done", BW'(done), '0);
      check("abort_top", BW'(top_out), '0);
      repeat (30) @(negedge Clk);
      check("abort_idle", BW'(busy), '0);

      // Reset wins over a simultaneous start.
      Reset = 1'b1;
      start = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      start = 1'b0;
      check("rst_prio_busy", BW'(busy), '0);
      @(negedge Clk);
      check("rst_prio_busy2", BW'(busy), '0);

      // LFSR back at seed: hole 5 again.
      eb = '0;
      eb[9:0] = 10'h3DF;
      run_op("t7", '0, 3'd1, eb, 1'b0, 1'b0);

      repeat (3) @(negedge Clk);
      check("pending_expect", BW'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
